// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared byte width and feeder state encoding for the uart tx path
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_feed_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - parameterised ring-buffer FIFO with occupancy count
module sync_fifo #(
    parameter int   DEPTH = 16,
    parameter int   WIDTH = 8,
    localparam int  AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic [AW:0]      count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Full is judged on the pre-edge count, so a pop never makes room for a same-edge push.
    assign full_o     = (count_q == FULL_CNT);
    assign empty_o    = (count_q == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - host byte buffer that feeds the uart transmitter one byte per busy period
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [BYTE_W-1:0] uart_din,
    output logic              uart_wr_en,
    input  logic              uart_tx_busy,
    output logic [AW:0]       count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    input  logic              ovf_clr,
    output logic              tx_idle
);

    tx_feed_state_t    state_q, state_d;
    logic [BYTE_W-1:0] din_q, din_d;
    logic              wr_en_q, wr_en_d;
    logic              ovf_q, ovf_d;
    logic              pop;
    logic [BYTE_W-1:0] fifo_rdata;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk_i       (clk_50m),
        .rst_ni      (rst_n),
        .push_i      (wr_valid),
        .push_data_i (wr_data),
        .pop_i       (pop),
        .pop_data_o  (fifo_rdata),
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty)
    );

    // The transmitter raises busy a cycle after the strobe, so WAIT_BUSY must see it rise before WAIT_DONE waits for it to fall.
    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        wr_en_d = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !uart_tx_busy) begin
                    pop     = 1'b1;
                    din_d   = fifo_rdata;
                    wr_en_d = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (uart_tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A rejected offer on the same edge as a clear keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_valid && full) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            din_q   <= '0;
            wr_en_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
            wr_en_q <= wr_en_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wr_ready   = !full;
    assign uart_din   = din_q;
    assign uart_wr_en = wr_en_q;
    assign overflow   = ovf_q;
    assign tx_idle    = empty && (state_q == IDLE) && !uart_tx_busy;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte buffer and feeder that sits directly upstream of the uart transmitter path.
- Accepts bytes from a host-side valid/ready interface into a DEPTH-entry FIFO.
- Drives the uart din/wr_en inputs one byte at a time, pacing itself on tx_busy, so the host never has to poll the transmitter.
- One instance per uart, clocked on the same 50 MHz clock.

Parameters:
DEPTH, 16, FIFO entries; power of 2, at least 2.
AW, $clog2(DEPTH), pointer width; derived localparam, not overridable.

Ports:
clk_50m  input  1  system clock; all logic is rising-edge.
rst_n  input  1  asynchronous active-low reset.
wr_data  input  8  byte from host.
wr_valid  input  1  host offers wr_data this cycle.
wr_ready  output  1  equals !full; a push happens on an edge where wr_valid && wr_ready.
uart_din  output  8  byte to the uart din input; registered.
uart_wr_en  output  1  one-cycle load strobe to the uart wr_en input; registered.
uart_tx_busy  input  1  from the uart tx_busy output.
count  output  AW+1  entries currently stored, 0..DEPTH.
empty  output  1  count == 0.
full  output  1  count == DEPTH.
overflow  output  1  sticky; set when wr_valid is high while full.
ovf_clr  input  1  clears overflow.
tx_idle  output  1  empty && state==IDLE && !uart_tx_busy.

Behaviour:
- Reset (async assert, sync release): rd_ptr=0, wr_ptr=0, count=0, state=IDLE, uart_din=0, uart_wr_en=0, overflow=0. Outputs therefore reset to wr_ready=1, empty=1, full=0. A byte already inside the transmitter is not tracked and completes on its own.
- Storage: ring buffer, AW-bit pointers wrapping modulo DEPTH, DEPTH x 8 register array with no reset on the data.
- Push: on edge with wr_valid && !full: mem[wr_ptr]<=wr_data, wr_ptr++.
  - full is evaluated before any same-cycle pop, so a push while full is rejected even if a pop occurs that cycle.
- Overflow: an edge with wr_valid && full sets overflow. ovf_clr clears it. If both occur on the same edge, set wins.
- Pop: happens on the IDLE->LOAD transition: uart_din<=mem[rd_ptr], rd_ptr++.
- Count: push only +1; pop only -1; push and pop on the same edge leave count unchanged.
- Feeder FSM states, in order IDLE, LOAD, WAIT_BUSY, WAIT_DONE:
  - IDLE: if !empty && !uart_tx_busy -> pop, uart_wr_en<=1, go LOAD. Otherwise stay.
  - LOAD: uart_wr_en<=0; go WAIT_BUSY. uart_wr_en is therefore high for exactly one cycle.
  - WAIT_BUSY: if uart_tx_busy -> WAIT_DONE, else stay. The transmitter raises busy the cycle after it samples wr_en.
  - WAIT_DONE: if !uart_tx_busy -> IDLE, else stay.
- uart_din holds its value from the LOAD edge until the next pop.
- Latency: a push at edge N into an empty FIFO with the FSM in IDLE and the uart not busy gives uart_wr_en high between edges N+1 and N+2.
- Back-to-back bytes:
  - The next uart_wr_en asserts no earlier than 1 cycle after tx_busy falls (WAIT_DONE->IDLE, then IDLE->LOAD).
  - Exactly one byte is loaded per tx_busy high period; no bytes are dropped or duplicated.
- Simultaneous push and pop with count==1 is legal: count stays 1, and the new byte is sent next.
- uart_tx_busy is synchronous to clk_50m; no synchronizer is required.

Decomposition:
- Package uart_pkg holds:
  - BYTE_W=8.
  - State enum tx_feed_state_t (IDLE, LOAD, WAIT_BUSY, WAIT_DONE), 2-bit encoding.
- One natural sub-module: sync_fifo, a parameterised DEPTH/width ring buffer with push/pop/count/full/empty. It is reusable later for the receive side.
- uart_tx_fifo adds only the feeder FSM, the overflow flag and tx_idle.

Test Plan:
- Reset then idle: rst_n low mid-run -> count=0, empty=1, wr_ready=1, uart_wr_en=0 immediately (async); no strobe until a push.
- Single byte 0xA5 pushed at edge N, busy model raises tx_busy 1 cycle after wr_en for 10 cycles -> uart_wr_en high only in cycle N+1..N+2, uart_din=0xA5, tx_idle=1 after busy falls.
- Push 0x01..0x10 (DEPTH=16) back-to-back -> full=1 after 16th push, wr_ready=0; 17th offer 0x55 rejected with overflow=1; uart receives 0x01..0x10 in order, one strobe per busy period.
- Wrap-around: 40 bytes through DEPTH=16 with random wr_valid gaps -> output sequence equals input sequence; count never exceeds 16 or goes negative.
- Simultaneous push/pop at count=16 -> push rejected, count=15; at count=1 -> count stays 1.
- ovf_clr and set on the same edge -> overflow stays 1; ovf_clr alone -> 0.
